// File: rtl/snake_pkg.sv
// Shared definitions for the 7-segment snake sequencer.
//   state_t          : FSM encoding, also presented on the state output
//   DEF_CNT_LENGTH   : default number of pattern positions per lap
//   DEF_TICK_DIV     : default clk cycles per snake step
//   DEF_MAX_RUNS     : default number of laps before the game stops
package snake_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_CNT_LENGTH = 8;
  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_MAX_RUNS   = 9;

endpackage

// File: rtl/snake_seq_ctrl_if.sv
// Control/status bundle between the button logic, the sequencer and the
// segment pattern decoder.
//   master : drives start/pause/dir_in, observes the sequencer status
//   slave  : the sequencer itself
// Signals:
//   start     one-cycle pulse, begin a new game
//   pause     one-cycle pulse, toggle RUN<->PAUSE
//   dir_in    direction for the next game (1=up, 0=down)
//   step_tick one-cycle pulse coincident with each ptn_cnt update
//   ptn_cnt   current snake position
//   updn      latched direction
//   run_cnt   current lap number
//   run_stop  high while the game is finished
//   state     IDLE=0, RUN=1, PAUSE=2, DONE=3
interface snake_seq_ctrl_if;

  logic       start;
  logic       pause;
  logic       dir_in;
  logic       step_tick;
  logic [4:0] ptn_cnt;
  logic       updn;
  logic [3:0] run_cnt;
  logic       run_stop;
  logic [1:0] state;

  modport master (
    output start, pause, dir_in,
    input  step_tick, ptn_cnt, updn, run_cnt, run_stop, state
  );

  modport slave (
    input  start, pause, dir_in,
    output step_tick, ptn_cnt, updn, run_cnt, run_stop, state
  );

endinterface

// File: rtl/snake_tick_div.sv
// Step-rate divider for the snake sequencer.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   en   : count enable (sequencer in RUN); when low the count freezes
//   clr  : restart the count from zero (new game accepted)
//   tick : high on the cycle the count wraps, i.e. the cycle a step is taken
module snake_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div;

  // Combinational so the top can register step_tick on the same edge that
  // moves ptn_cnt.
  assign tick = en && (div == DIV_LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div <= '0;
    end else if (en) begin
      div <= tick ? '0 : div + W'(1);
    end
  end

endmodule

// File: rtl/snake_seq_ctrl.sv
// Sequencer for the 7-segment snake: FSM, step position and lap counters.
//   clk : system clock, single domain
//   rst : synchronous active-high reset
//   bus : slave side of snake_seq_ctrl_if (start/pause/dir_in in; step_tick,
//         ptn_cnt, updn, run_cnt, run_stop, state out, all registered)
module snake_seq_ctrl
  import snake_pkg::*;
#(
  parameter int CNT_LENGTH = DEF_CNT_LENGTH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int MAX_RUNS   = DEF_MAX_RUNS
) (
  input  logic             clk,
  input  logic             rst,
  snake_seq_ctrl_if.slave  bus
);

  localparam logic [4:0] PTN_LAST = 5'(CNT_LENGTH - 1);
  localparam logic [3:0] RUN_LAST = 4'(MAX_RUNS);

  state_t     state_q, state_d;
  logic [4:0] ptn_q, ptn_d;
  logic [3:0] run_q, run_d;
  logic       updn_q, updn_d;
  logic       stop_q, stop_d;
  logic       tick_q, tick_d;

  logic start_ok;
  logic div_tick;

  // start is honoured only between games; mid-game presses are dropped.
  assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  snake_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == S_RUN),
    .clr  (start_ok),
    .tick (div_tick)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptn_d   = ptn_q;
    run_d   = run_q;
    updn_d  = updn_q;
    stop_d  = stop_q;
    tick_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over a simultaneous pause, which is simply not looked at.
        if (start_ok) begin
          state_d = S_RUN;
          updn_d  = bus.dir_in;
          ptn_d   = bus.dir_in ? 5'd0 : PTN_LAST;
          run_d   = 4'd1;
          stop_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (div_tick) begin
          tick_d = 1'b1;
          if (updn_q && ptn_q < PTN_LAST) begin
            ptn_d = ptn_q + 5'd1;
          end else if (!updn_q && ptn_q > 5'd0) begin
            ptn_d = ptn_q - 5'd1;
          end else if (run_q < RUN_LAST) begin
            ptn_d = updn_q ? 5'd0 : PTN_LAST;
            run_d = run_q + 4'd1;
          end else begin
            // Final lap end: position and lap count hold at their last values.
            state_d = S_DONE;
            stop_d  = 1'b1;
          end
        end
        // A coincident step has already been applied above; finishing the
        // game takes precedence over a pause landing on the same edge.
        if (bus.pause && state_d == S_RUN) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (bus.pause) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptn_q   <= 5'd0;
      run_q   <= 4'd0;
      updn_q  <= 1'b1;
      stop_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptn_q   <= ptn_d;
      run_q   <= run_d;
      updn_q  <= updn_d;
      stop_q  <= stop_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.ptn_cnt   = ptn_q;
  assign bus.run_cnt   = run_q;
  assign bus.updn      = updn_q;
  assign bus.run_stop  = stop_q;
  assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_snake_seq_ctrl.sv
// Self-checking bench for snake_seq_ctrl (CNT_LENGTH=8, TICK_DIV=2,
// MAX_RUNS=3). A reference model predicts each step; predicted steps go into
// a scoreboard queue drained by an independent monitor on step_tick.
module tb_snake_seq_ctrl;

  localparam int L  = 8;
  localparam int TD = 2;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_seq_ctrl_if bus ();

  snake_seq_ctrl #(
    .CNT_LENGTH (L),
    .TICK_DIV   (TD),
    .MAX_RUNS   (MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Game view: a step happens after every TD cycles spent running; the snake
  // walks its lap, wraps into the next lap, and stops after the last lap.
  typedef struct {
    int pos;
    int lap;
    bit dir;
    int st;
  } exp_t;

  exp_t sb_q[$];

  int m_st, m_pos, m_lap, m_run_cycles, m_steps;
  bit m_dir, m_stop, m_tick;

  task automatic model_step(input bit r, input bit s, input bit p, input bit d);
    int lap_end_pos;
    m_tick = 1'b0;
    if (r) begin
      m_st = 0; m_pos = 0; m_dir = 1'b1; m_lap = 0; m_stop = 1'b0;
      m_run_cycles = 0; m_steps = 0;
      return;
    end
    case (m_st)
      0, 3: if (s) begin
        m_st = 1; m_dir = d; m_pos = d ? 0 : L - 1; m_lap = 1; m_stop = 1'b0;
        m_run_cycles = 0; m_steps = 0;
      end
      1: begin
        m_run_cycles++;
        if (m_run_cycles % TD == 0) begin
          m_tick = 1'b1;
          m_steps++;
          lap_end_pos = m_dir ? L - 1 : 0;
          if (m_pos != lap_end_pos) m_pos = m_dir ? m_pos + 1 : m_pos - 1;
          else if (m_lap < MR) begin
            m_lap++;
            m_pos = m_dir ? 0 : L - 1;
          end else begin
            m_st = 3;
            m_stop = 1'b1;
          end
        end
        if (p && m_st == 1) m_st = 2;
        if (m_tick) sb_q.push_back('{m_pos, m_lap, m_dir, m_st});
      end
      2: if (p) m_st = 1;
      default: m_st = 0;
    endcase
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.step_tick === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: got step_tick=1, expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("tick_ptn",   32'(bus.ptn_cnt), 32'(e.pos));
        check("tick_run",   32'(bus.run_cnt), 32'(e.lap));
        check("tick_updn",  32'(bus.updn),    32'(e.dir));
        check("tick_state", 32'(bus.state),   32'(e.st));
      end
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model, then compares the full
  // registered output set against the model on the falling edge.
  task automatic cycle(input bit r, input bit s, input bit p, input bit d);
    rst        = r;
    bus.start  = s;
    bus.pause  = p;
    bus.dir_in = d;
    model_step(r, s, p, d);
    @(posedge clk);
    @(negedge clk);
    check("outputs",
          {18'd0, bus.state, bus.ptn_cnt, bus.run_cnt, bus.updn, bus.run_stop, bus.step_tick},
          {18'd0, 2'(m_st), 5'(m_pos), 4'(m_lap), m_dir, m_stop, m_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic run_to_done(input string name);
    int budget;
    budget = 200;
    while (m_st != 3 && budget > 0) begin
      cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      budget--;
    end
    if (m_st != 3) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_budget: got no DONE, expected DONE within 200 cycles", name);
    end
  endtask

  logic [4:0] snap_ptn;
  logic [3:0] snap_run;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; bus.dir_in = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 1. Reset with random inputs; start during reset is ignored.
    cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("reset_vals",
          {bus.state, bus.ptn_cnt, bus.run_cnt, bus.updn, bus.run_stop, bus.step_tick},
          {2'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0});

    // 2. Up game.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("up_start", {bus.state, bus.ptn_cnt, bus.run_cnt}, {2'd1, 5'd0, 4'd1});
    run_to_done("up");
    check("up_done", {bus.state, bus.ptn_cnt, bus.run_cnt, bus.run_stop},
          {2'd3, 5'd7, 4'd3, 1'b1});
    idle(6);

    // 3. Down game.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("down_start", {bus.state, bus.ptn_cnt, bus.updn}, {2'd1, 5'd7, 1'b0});
    run_to_done("down");
    check("down_done", {bus.state, bus.ptn_cnt, bus.run_cnt, bus.run_stop},
          {2'd3, 5'd0, 4'd3, 1'b1});

    // 4. Pause at cycle 5 after start, hold 10 cycles, resume.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    snap_ptn = bus.ptn_cnt;
    snap_run = bus.run_cnt;
    idle(10);
    check("pause_frozen", {bus.state, bus.ptn_cnt, bus.run_cnt}, {2'd2, snap_ptn, snap_run});
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_to_done("pause");

    // 5. Races: pause on a step edge, start mid-run, start+pause in IDLE.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    while ((m_run_cycles + 1) % TD != 0) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_on_step", {bus.state, bus.step_tick}, {2'd2, 1'b1});
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_in_run", {bus.state, bus.updn}, {2'd1, 1'b1});
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("start_pause_idle", {bus.state, bus.updn, bus.ptn_cnt}, {2'd1, 1'b0, 5'd7});

    // 6. Reset at step 10, then a full game and restart from DONE.
    while (m_steps < 10) cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_reset",
          {bus.state, bus.ptn_cnt, bus.run_cnt, bus.updn, bus.run_stop},
          {2'd0, 5'd0, 4'd0, 1'b1, 1'b0});
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    run_to_done("restart");
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_from_done", {bus.state, bus.run_stop, bus.run_cnt, bus.ptn_cnt},
          {2'd1, 1'b0, 4'd1, 5'd7});

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)));
    end

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
